demux2_stream: RTL and testbench
================================

Name: demux2_stream

Overview:
- Registered 1-to-2 stream demultiplexer. It is the distribution counterpart of the 2:1 bus mux.
- Accepts one WIDTH-bit data stream with valid/ready handshake.
- Steers each accepted word to channel A or channel B per a select bit sampled at transfer.
- Each channel has its own 2-entry buffer, so a stalled channel never corrupts the other. Sits between the datapath front end and the encrypt/decrypt engines.

Parameters:
- WIDTH, 8, data bus width in bits.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- bus_i  input  WIDTH  incoming data word.
- valid_i  input  1  bus_i holds a valid word.
- select_i  input  1  destination: 0 = channel A, 1 = channel B; sampled only on transfer.
- ready_o  output  1  block can accept a word for the channel named by select_i.
- bus_a_o  output  WIDTH  channel A head word.
- valid_a_o  output  1  channel A word available.
- ready_a_i  input  1  channel A consumer accepts.
- bus_b_o  output  WIDTH  channel B head word.
- valid_b_o  output  1  channel B word available.
- ready_b_i  input  1  channel B consumer accepts.

Behaviour:
- Input transfer: valid_i && ready_o on a rising edge.
- Output transfer: valid_x_o && ready_x_i on a rising edge.
- ready_o = select_i ? !full_b : !full_a. This path is combinational from select_i and registered occupancy only, never from ready_x_i.
- Each channel is a 2-entry FIFO:
  - state EMPTY (count 0) -> ONE (count 1) -> FULL (count 2).
  - Push and pop in the same cycle leave the count unchanged.
  - Pop from EMPTY is impossible because valid is low.
  - Push into FULL is impossible because ready_o is low.
- Latency: a word accepted at edge n appears on bus_x_o with valid_x_o high after edge n, i.e. 1 cycle. There is no combinational pass-through.
- Throughput: one word per cycle per channel when the consumer holds ready_x_i high.
- Ordering: words within a channel leave in acceptance order. There is no ordering relation between channels.
- bus_x_o is the head entry while valid_x_o = 1. Its value while valid_x_o = 0 is don't-care but stable, holding the last head.
- Stable output: once valid_x_o rises, bus_x_o and valid_x_o hold until that output's transfer completes.
- Unselected channel: its FIFO is untouched by input activity and may keep draining.
- Reset (async assert, any time, including mid-transfer):
  - both counts = 0.
  - valid_a_o = valid_b_o = 0.
  - bus_a_o = bus_b_o = 0.
  - ready_o = 1 after reset.
  - In-flight words are discarded.
  - Deassertion is synchronised externally; the block is first active on the first edge after rst_ni rises.
- select_i and bus_i may change freely while valid_i = 0.

Optional Feature:
- Macro DEMUX2_STATS_EN.
- When defined:
  - adds ports cnt_a_o and cnt_b_o, outputs, 16 bits each.
  - Each counts completed output transfers on its channel.
  - Counters saturate at 16'hFFFF and reset to 0.
  - Adds input clr_cnt_i, 1 bit, a synchronous clear of both counters. Clear wins over a same-cycle increment.
- When undefined: these ports and registers do not exist. Functional behaviour is otherwise identical.

Decomposition:
- Package demux2_pkg:
  - enum ch_sel_t {CH_A = 1'b0, CH_B = 1'b1}.
  - enum fifo_state_t {EMPTY, ONE, FULL}.
  - localparam STATS_W = 16.
- Sub-module fifo2 (parameter WIDTH): 2-entry FIFO with push/pop/full/empty/head.
- demux2_stream instantiates fifo2 twice, plus the steering logic and optional counters.

Test Plan:
- Reset: hold rst_ni = 0 for 3 cycles, release -> valid_a_o = valid_b_o = 0, bus_a_o = bus_b_o = 8'h00, ready_o = 1.
- Steering: send 8'hA5 with select 0, then 8'h3C with select 1, both consumers ready -> bus_a_o = A5 one cycle after its accept, bus_b_o = 3C one cycle after its accept, no cross-talk.
- Backpressure: ready_a_i = 0, push 8'h01, 8'h02, 8'h03 to A -> ready_o drops after the second accept, 8'h03 is held. Raise ready_a_i -> outputs 01, 02, 03 in order.
- Isolation: channel A FULL and stalled, push 8'h77 to B -> accepted immediately, appears on bus_b_o next cycle, A contents unchanged.
- Full throughput: both ready, alternate select every cycle over 16 words -> ready_o stays 1, no bubbles, per-channel order preserved.
- Mid-operation reset: assert rst_ni low asynchronously while A is FULL -> valid_a_o falls without a clock edge, prior words never reappear. With DEMUX2_STATS_EN defined: 5 A transfers give cnt_a_o = 5; clr_cnt_i gives 0.

Source files
------------

// File: rtl/demux2_pkg.sv
// Shared types and helpers for the demux2_stream 1-to-2 stream demultiplexer.
package demux2_pkg;

    typedef enum logic {
        CH_A = 1'b0,
        CH_B = 1'b1
    } ch_sel_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } fifo_state_t;

    localparam int STATS_W = 16;

    function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
        return (v == {STATS_W{1'b1}}) ? v : v + {{(STATS_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/demux2_stream_fifo2.sv
// Two-entry FIFO; entry 0 is always the head and is driven straight from a register.
module fifo2
    import demux2_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    fifo_state_t      state_r;
    fifo_state_t      state_s;
    logic [WIDTH-1:0] mem0_r;
    logic [WIDTH-1:0] mem1_r;

    // Occupancy state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= EMPTY;
        end else begin
            state_r <= state_s;
        end
    end

    // Occupancy next state; push/pop together keep the count.
    always_comb begin
        state_s = state_r;
        case (state_r)
            EMPTY: begin
                if (push) state_s = ONE;
                else      state_s = EMPTY;
            end
            ONE: begin
                if (push && !pop)      state_s = FULL;
                else if (pop && !push) state_s = EMPTY;
                else                   state_s = ONE;
            end
            FULL: begin
                if (pop && !push) state_s = ONE;
                else              state_s = FULL;
            end
            default: state_s = EMPTY;
        endcase
    end

    // Entry storage; a pop that empties the FIFO leaves the old head in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem0_r <= {WIDTH{1'b0}};
            mem1_r <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                EMPTY: begin
                    if (push) mem0_r <= din;
                end
                ONE: begin
                    if (push && pop) mem0_r <= din;
                    else if (push)   mem1_r <= din;
                end
                FULL: begin
                    if (pop) begin
                        mem0_r <= mem1_r;
                        if (push) mem1_r <= din;
                    end
                end
                default: begin
                    mem0_r <= {WIDTH{1'b0}};
                    mem1_r <= {WIDTH{1'b0}};
                end
            endcase
        end
    end

    assign full  = (state_r == FULL);
    assign empty = (state_r == EMPTY);
    assign head  = mem0_r;

endmodule

// File: rtl/demux2_stream.sv
// Registered 1-to-2 stream demultiplexer with a 2-entry FIFO per channel.
// Optional per-channel transfer counters when DEMUX2_STATS_EN is defined.
module demux2_stream
    import demux2_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [WIDTH-1:0]   bus_i,
    input  logic               valid_i,
    input  logic               select_i,
    output logic               ready_o,
    output logic [WIDTH-1:0]   bus_a_o,
    output logic               valid_a_o,
    input  logic               ready_a_i,
    output logic [WIDTH-1:0]   bus_b_o,
    output logic               valid_b_o,
    input  logic               ready_b_i
`ifdef DEMUX2_STATS_EN
    ,
    input  logic               clr_cnt_i,
    output logic [STATS_W-1:0] cnt_a_o,
    output logic [STATS_W-1:0] cnt_b_o
`endif
);

    ch_sel_t sel_s;
    logic    full_a_s, full_b_s, empty_a_s, empty_b_s;
    logic    push_a_s, push_b_s, pop_a_s, pop_b_s;

    assign sel_s = ch_sel_t'(select_i);

    // Ready depends only on select and registered occupancy, never on consumer ready.
    assign ready_o  = (sel_s == CH_B) ? !full_b_s : !full_a_s;
    assign push_a_s = valid_i && ready_o && (sel_s == CH_A);
    assign push_b_s = valid_i && ready_o && (sel_s == CH_B);

    assign valid_a_o = !empty_a_s;
    assign valid_b_o = !empty_b_s;
    assign pop_a_s   = valid_a_o && ready_a_i;
    assign pop_b_s   = valid_b_o && ready_b_i;

    fifo2 #(.WIDTH(WIDTH)) u_fifo_a (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .push  (push_a_s),
        .din   (bus_i),
        .pop   (pop_a_s),
        .full  (full_a_s),
        .empty (empty_a_s),
        .head  (bus_a_o)
    );

    fifo2 #(.WIDTH(WIDTH)) u_fifo_b (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .push  (push_b_s),
        .din   (bus_i),
        .pop   (pop_b_s),
        .full  (full_b_s),
        .empty (empty_b_s),
        .head  (bus_b_o)
    );

`ifdef DEMUX2_STATS_EN
    logic [STATS_W-1:0] cnt_a_r, cnt_b_r;

    // Saturating output-transfer counters; clear beats a same-cycle increment.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_a_r <= {STATS_W{1'b0}};
            cnt_b_r <= {STATS_W{1'b0}};
        end else if (clr_cnt_i) begin
            cnt_a_r <= {STATS_W{1'b0}};
            cnt_b_r <= {STATS_W{1'b0}};
        end else begin
            if (pop_a_s) cnt_a_r <= sat_inc(cnt_a_r);
            if (pop_b_s) cnt_b_r <= sat_inc(cnt_b_r);
        end
    end

    assign cnt_a_o = cnt_a_r;
    assign cnt_b_o = cnt_b_r;
`endif

endmodule

// File: tb/tb_demux2_stream.sv
// Scoreboard bench for demux2_stream; covers the counters when DEMUX2_STATS_EN is defined.
module tb_demux2_stream;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic [7:0] bus_i;
    logic       valid_i, select_i, ready_o;
    logic [7:0] bus_a_o, bus_b_o;
    logic       valid_a_o, valid_b_o, ready_a_i, ready_b_i;
`ifdef DEMUX2_STATS_EN
    logic        clr_cnt_i = 1'b0;
    logic [15:0] cnt_a_o, cnt_b_o;
`endif

    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    logic [7:0] last_a = 8'h00;
    logic [7:0] last_b = 8'h00;
    int         err_cnt = 0;
    int         chk_cnt = 0;
    int         a_pops = 0;
    int         b_pops = 0;

    always #5 clk = ~clk;

    demux2_stream #(.WIDTH(8)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .bus_i     (bus_i),
        .valid_i   (valid_i),
        .select_i  (select_i),
        .ready_o   (ready_o),
        .bus_a_o   (bus_a_o),
        .valid_a_o (valid_a_o),
        .ready_a_i (ready_a_i),
        .bus_b_o   (bus_b_o),
        .valid_b_o (valid_b_o),
        .ready_b_i (ready_b_i)
`ifdef DEMUX2_STATS_EN
        ,
        .clr_cnt_i (clr_cnt_i),
        .cnt_a_o   (cnt_a_o),
        .cnt_b_o   (cnt_b_o)
`endif
    );

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs after negedge, check against the model, then clock.
    task automatic step(input logic v, input logic sel, input logic [7:0] d,
                        input logic ra, input logic rb);
        logic [7:0] w;
        valid_i   = v;
        select_i  = sel;
        bus_i     = d;
        ready_a_i = ra;
        ready_b_i = rb;
        #1;
        check_value("valid_a", {31'd0, valid_a_o}, {31'd0, q_a.size() != 0});
        check_value("valid_b", {31'd0, valid_b_o}, {31'd0, q_b.size() != 0});
        check_value("ready", {31'd0, ready_o}, {31'd0, sel ? (q_b.size() < 2) : (q_a.size() < 2)});
        check_value("bus_a", {24'd0, bus_a_o}, {24'd0, (q_a.size() != 0) ? q_a[0] : last_a});
        check_value("bus_b", {24'd0, bus_b_o}, {24'd0, (q_b.size() != 0) ? q_b[0] : last_b});
        if (valid_a_o && ra && q_a.size() != 0) begin
            last_a = q_a.pop_front();
            a_pops++;
        end
        if (valid_b_o && rb && q_b.size() != 0) begin
            last_b = q_b.pop_front();
            b_pops++;
        end
        if (v && ready_o) begin
            w = d;
            if (sel) q_b.push_back(w);
            else     q_a.push_back(w);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_ni    = 1'b0;
        valid_i   = 1'b0;
        select_i  = 1'b0;
        bus_i     = 8'h00;
        ready_a_i = 1'b0;
        ready_b_i = 1'b0;
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        #1;
        check_value("rst_valid_a", {31'd0, valid_a_o}, 32'd0);
        check_value("rst_valid_b", {31'd0, valid_b_o}, 32'd0);
        check_value("rst_bus_a", {24'd0, bus_a_o}, 32'd0);
        check_value("rst_bus_b", {24'd0, bus_b_o}, 32'd0);
        check_value("rst_ready", {31'd0, ready_o}, 32'd1);
        @(negedge clk);

        // Steering
        step(1'b1, 1'b0, 8'hA5, 1'b1, 1'b1);
        check_value("steer_a_lat", {23'd0, valid_a_o, bus_a_o}, {23'd0, 1'b1, 8'hA5});
        step(1'b1, 1'b1, 8'h3C, 1'b1, 1'b1);
        check_value("steer_b_lat", {23'd0, valid_b_o, bus_b_o}, {23'd0, 1'b1, 8'h3C});
        check_value("steer_no_xtalk", {31'd0, valid_a_o}, 32'd0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

        // Backpressure on A, then isolation through B
        step(1'b1, 1'b0, 8'h01, 1'b0, 1'b1);
        step(1'b1, 1'b0, 8'h02, 1'b0, 1'b1);
        step(1'b1, 1'b0, 8'h03, 1'b0, 1'b1);
        step(1'b1, 1'b1, 8'h77, 1'b0, 1'b1);
        check_value("iso_b", {23'd0, valid_b_o, bus_b_o}, {23'd0, 1'b1, 8'h77});
        check_value("iso_a_head", {23'd0, valid_a_o, bus_a_o}, {23'd0, 1'b1, 8'h01});
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 1'b0, 8'h03, 1'b1, 1'b1);
        step(1'b1, 1'b0, 8'h03, 1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

        // Full throughput, alternating channels
        for (int i = 0; i < 16; i++) begin
            step(1'b1, i[0], 8'h10 + 8'(i), 1'b1, 1'b1);
        end
        repeat (2) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        check_value("thru_pops", a_pops + b_pops, 32'd22);

`ifdef DEMUX2_STATS_EN
        clr_cnt_i = 1'b1;
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        clr_cnt_i = 1'b0;
        check_value("cnt_clr0", {16'd0, cnt_a_o}, 32'd0);
        a_pops = 0;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h40 + 8'(i), 1'b1, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        check_value("cnt_a5", {16'd0, cnt_a_o}, a_pops);
        check_value("cnt_a5_abs", {16'd0, cnt_a_o}, 32'd5);
        step(1'b1, 1'b0, 8'h55, 1'b1, 1'b1);
        clr_cnt_i = 1'b1;
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        clr_cnt_i = 1'b0;
        check_value("cnt_clr_wins", {16'd0, cnt_a_o}, 32'd0);
        check_value("cnt_b_clr", {16'd0, cnt_b_o}, 32'd0);
`endif

        // Mid-operation asynchronous reset with A full
        step(1'b1, 1'b0, 8'hE1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'hE2, 1'b0, 1'b0);
        #2;
        rst_ni = 1'b0;
        #1;
        check_value("arst_valid_a", {31'd0, valid_a_o}, 32'd0);
        check_value("arst_bus_a", {24'd0, bus_a_o}, 32'd0);
        check_value("arst_ready", {31'd0, ready_o}, 32'd1);
        q_a.delete();
        q_b.delete();
        last_a = 8'h00;
        last_b = 8'h00;
        @(negedge clk);
        rst_ni = 1'b1;
        repeat (2) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        step(1'b1, 1'b0, 8'h9A, 1'b1, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
